scariv_credit_return_slave: RTL and testbench

SCARIV_CREDIT_RETURN_SLAVE -- requirements
Module: scariv_credit_return_slave

---
 rtl/scariv_credit_return_slave.sv | 112 +++++++++++
 tb/tb_scariv_credit_return_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scariv_credit_return_slave.sv
// Credit return slave: tracks entries held by a backend queue and returns
// freed credits to the dispatch master, throttled to MAXIMAL_VAL per cycle.
//
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_dispatch_valid/_val     credits granted to this queue this cycle
//   i_get_return              one bit per entry freed this cycle
//   i_flush_return_valid/_val bulk free of flushed entries
//   o_return_valid/_vals      registered credit return to the master
//   o_occupancy               entries currently held
//   o_idle                    nothing held, nothing waiting to be returned
//   o_credit_err              sticky underflow/overflow flag
module scariv_credit_return_slave #(
    parameter  int MAX_CREDITS = 16,
    parameter  int RET_PORTS   = 2,
    parameter  int MAXIMAL_VAL = 4,
    localparam int W           = $clog2(MAX_CREDITS) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_dispatch_valid,
    input  logic [W-1:0]         i_dispatch_val,
    input  logic [RET_PORTS-1:0] i_get_return,
    input  logic                 i_flush_return_valid,
    input  logic [W-1:0]         i_flush_return_val,
    output logic                 o_return_valid,
    output logic [W-1:0]         o_return_vals,
    output logic [W-1:0]         o_occupancy,
    output logic                 o_idle,
    output logic                 o_credit_err
);

    localparam logic [W:0]   MAXC_X = (W+1)'(MAX_CREDITS);
    localparam logic [W-1:0] MAXC_W = W'(MAX_CREDITS);
    localparam logic [W:0]   MAXV_X = (W+1)'(MAXIMAL_VAL);
    localparam logic [W-1:0] MAXV_W = W'(MAXIMAL_VAL);

    logic [W-1:0] pending_q, pending_d;
    logic [W-1:0] occ_q, occ_d;
    logic [W-1:0] ret_vals_q, ret_vals_d;
    logic         ret_valid_q, ret_valid_d;
    logic         err_q, err_d;

    logic [W:0] new_ret;
    logic [W:0] avail;
    logic [W:0] remain;
    logic [W:0] occ_sum;
    logic [W:0] occ_diff;

    always_comb begin
        new_ret = '0;
        for (int i = 0; i < RET_PORTS; i++) begin
            new_ret = new_ret + {{W{1'b0}}, i_get_return[i]};
        end
        if (i_flush_return_valid) begin
            new_ret = new_ret + {1'b0, i_flush_return_val};
        end

        // Returns: send up to MAXIMAL_VAL, carry the rest.
        avail       = {1'b0, pending_q} + new_ret;
        ret_vals_d  = (avail > MAXV_X) ? MAXV_W : avail[W-1:0];
        ret_valid_d = (ret_vals_d != '0);
        remain      = avail - {1'b0, ret_vals_d};

        err_d = err_q;
        if (remain > MAXC_X) begin
            pending_d = MAXC_W;
            err_d     = 1'b1;
        end else begin
            pending_d = remain[W-1:0];
        end

        // Occupancy: dispatch and frees land in the same update.
        occ_sum = {1'b0, occ_q};
        if (i_dispatch_valid) begin
            occ_sum = occ_sum + {1'b0, i_dispatch_val};
        end
        occ_diff = occ_sum - new_ret;
        if (new_ret > occ_sum) begin
            occ_d = '0;
            err_d = 1'b1;
        end else if (occ_diff > MAXC_X) begin
            occ_d = MAXC_W;
            err_d = 1'b1;
        end else begin
            occ_d = occ_diff[W-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pending_q   <= '0;
            occ_q       <= '0;
            ret_vals_q  <= '0;
            ret_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            occ_q       <= occ_d;
            ret_vals_q  <= ret_vals_d;
            ret_valid_q <= ret_valid_d;
            err_q       <= err_d;
        end
    end

    assign o_return_valid = ret_valid_q;
    assign o_return_vals  = ret_vals_q;
    assign o_occupancy    = occ_q;
    assign o_credit_err   = err_q;
    assign o_idle         = (occ_q == '0) && (pending_q == '0) && !ret_valid_q;

endmodule

// File: tb/tb_scariv_credit_return_slave.sv
// Bench for scariv_credit_return_slave: two instances (MAXIMAL_VAL 2 and 1)
// driven in lockstep, checked every cycle against an integer model.
module tb_scariv_credit_return_slave;

    localparam int MAXC = 16;
    localparam int W    = $clog2(MAXC) + 1;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         dv = 1'b0;
    logic [W-1:0] dval = '0;
    logic [1:0]   get = '0;
    logic         fv = 1'b0;
    logic [W-1:0] fval = '0;

    logic         rv0, rv1, idle0, idle1, err0, err1;
    logic [W-1:0] rvals0, rvals1, occ0, occ1;

    int n_chk = 0;
    int n_err = 0;

    int m_pend[2];
    int m_occ[2];
    int m_rvals[2];
    int m_err[2];
    int maxv[2] = '{2, 1};

    always #5 clk = ~clk;

    scariv_credit_return_slave #(
        .MAX_CREDITS(MAXC), .RET_PORTS(2), .MAXIMAL_VAL(2)
    ) u_dut0 (
        .i_clk(clk), .i_reset(i_reset),
        .i_dispatch_valid(dv), .i_dispatch_val(dval),
        .i_get_return(get),
        .i_flush_return_valid(fv), .i_flush_return_val(fval),
        .o_return_valid(rv0), .o_return_vals(rvals0),
        .o_occupancy(occ0), .o_idle(idle0), .o_credit_err(err0)
    );

    scariv_credit_return_slave #(
        .MAX_CREDITS(MAXC), .RET_PORTS(2), .MAXIMAL_VAL(1)
    ) u_dut1 (
        .i_clk(clk), .i_reset(i_reset),
        .i_dispatch_valid(dv), .i_dispatch_val(dval),
        .i_get_return(get),
        .i_flush_return_valid(fv), .i_flush_return_val(fval),
        .o_return_valid(rv1), .o_return_vals(rvals1),
        .o_occupancy(occ1), .o_idle(idle1), .o_credit_err(err1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 0;
            m_occ[k]   = 0;
            m_rvals[k] = 0;
            m_err[k]   = 0;
        end
    endfunction

    // One clock worth of the credit rules, in plain integers.
    function automatic void model_step();
        int freed, total, send, left, held;
        freed = int'(get[0]) + int'(get[1]) + (fv ? int'(fval) : 0);
        for (int k = 0; k < 2; k++) begin
            total = m_pend[k] + freed;
            send  = (total < maxv[k]) ? total : maxv[k];
            left  = total - send;
            m_rvals[k] = send;
            if (left > MAXC) begin
                m_pend[k] = MAXC;
                m_err[k]  = 1;
            end else begin
                m_pend[k] = left;
            end
            held = m_occ[k] + (dv ? int'(dval) : 0) - freed;
            if (held < 0) begin
                m_occ[k] = 0;
                m_err[k] = 1;
            end else if (held > MAXC) begin
                m_occ[k] = MAXC;
                m_err[k] = 1;
            end else begin
                m_occ[k] = held;
            end
        end
    endfunction

    task automatic verify();
        int g_rv, g_rvals, g_occ, g_idle, g_err, e_idle;
        for (int k = 0; k < 2; k++) begin
            g_rv    = (k == 0) ? int'(rv0)    : int'(rv1);
            g_rvals = (k == 0) ? int'(rvals0) : int'(rvals1);
            g_occ   = (k == 0) ? int'(occ0)   : int'(occ1);
            g_idle  = (k == 0) ? int'(idle0)  : int'(idle1);
            g_err   = (k == 0) ? int'(err0)   : int'(err1);
            e_idle  = (m_occ[k] == 0 && m_pend[k] == 0 && m_rvals[k] == 0)
                      ? 1 : 0;
            chk($sformatf("u%0d.ret_valid", k), g_rv, (m_rvals[k] != 0) ? 1 : 0);
            chk($sformatf("u%0d.ret_vals", k), g_rvals, m_rvals[k]);
            chk($sformatf("u%0d.occupancy", k), g_occ, m_occ[k]);
            chk($sformatf("u%0d.idle", k), g_idle, e_idle);
            chk($sformatf("u%0d.credit_err", k), g_err, m_err[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (i_reset) model_reset();
        else model_step();
        #1;
        verify();
    endtask

    task automatic idle_in();
        dv   = 1'b0;
        dval = '0;
        get  = '0;
        fv   = 1'b0;
        fval = '0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        #1;
        model_reset();
        verify();
        step();
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset with random inputs applied
        dv   = 1'b1;
        dval = W'($urandom_range(0, 31));
        get  = 2'($urandom_range(0, 3));
        fv   = 1'b1;
        fval = W'($urandom_range(0, 31));
        @(negedge clk);
        do_reset();
        chk("rst.idle", int'(idle0), 1);
        chk("rst.ret_valid", int'(rv0), 0);
        idle_in();
        step();

        // Single free
        dv = 1'b1; dval = 5'd3;
        step();
        idle_in();
        step();
        get = 2'b01;
        step();
        chk("single.ret_vals", int'(rvals0), 1);
        chk("single.occ", int'(occ0), 2);
        get = 2'b11;
        step();
        idle_in();
        repeat (4) step();

        // Drain throttling
        dv = 1'b1; dval = 5'd5;
        step();
        idle_in();
        fv = 1'b1; fval = 5'd5;
        step();
        chk("drain.r1", int'(rvals0), 2);
        idle_in();
        step();
        chk("drain.r2", int'(rvals0), 2);
        step();
        chk("drain.r3", int'(rvals0), 1);
        step();
        chk("drain.done_valid", int'(rv0), 0);
        chk("drain.done_idle", int'(idle0), 1);
        repeat (4) step();

        // Concurrent dispatch and return
        dv = 1'b1; dval = 5'd4;
        step();
        dv = 1'b1; dval = 5'd2; get = 2'b11;
        step();
        chk("conc.occ", int'(occ0), 4);
        chk("conc.ret_vals", int'(rvals0), 2);
        idle_in();
        fv = 1'b1; fval = 5'd4;
        step();
        idle_in();
        repeat (6) step();

        // Underflow
        get = 2'b01;
        step();
        chk("under.err", int'(err0), 1);
        chk("under.occ", int'(occ0), 0);
        chk("under.ret_vals", int'(rvals0), 1);
        idle_in();
        repeat (2) step();
        chk("under.sticky", int'(err0), 1);

        // Reset mid-drain
        do_reset();
        dv = 1'b1; dval = 5'd3;
        step();
        idle_in();
        fv = 1'b1; fval = 5'd3;
        step();
        chk("middrain.first", int'(rvals1), 1);
        idle_in();
        i_reset = 1'b1;
        #1;
        model_reset();
        verify();
        step();
        i_reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("middrain.quiet", int'(rv1), 0);
        end

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                idle_in();
                do_reset();
            end
            dv   = ($urandom_range(0, 2) == 0);
            dval = W'($urandom_range(0, 5));
            if ($urandom_range(0, 60) == 0) dval = W'($urandom_range(10, 31));
            get  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            fv   = ($urandom_range(0, 12) == 0);
            fval = W'($urandom_range(0, 6));
            if ($urandom_range(0, 60) == 0) fval = W'($urandom_range(16, 31));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
